timer_count_core: RTL and testbench
===================================

# timer_count_core

Counting engine of the 8-bit timer. It sits directly downstream of the timer register file and consumes its control fields: start, mode, prescaler, clock select, limits, init value and match values. It produces the running count and the single-cycle overflow/match events that the register file latches into status flags. It also drives the timer output pin in toggle or PWM mode.

## Interface
- WIDTH, 8, counter and compare width
- PRE_W, 3, prescaler select width; divide ratio is 2^prescaler

- clk  in  1  system clock; one clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  run enable
- count_mode  in  1  0 = up (sawtooth), 1 = up/down (triangle)
- clock_select  in  1  0 = prescaled clk, 1 = external input
- edge_mode  in  1  external edge: 0 = rising, 1 = falling
- prescaler  in  PRE_W  divide select
- force_free  in  1  ignore limits, run 0..2^WIDTH-1
- count_init  in  WIDTH  load value
- cnt_init_wr  in  1  one-cycle load strobe
- count_min, count_max  in  WIDTH  wrap limits
- match_0_value, match_1_value  in  WIDTH  compare values
- pwm_mode  in  1  0 = toggle output on match_0, 1 = PWM
- inv  in  1  invert tmr_out
- ext_clk_in  in  1  asynchronous external count source
- count  out  WIDTH  current count; reset 0
- overflow  out  1  wrap pulse; reset 0
- match_0, match_1  out  1  compare pulses; reset 0
- tmr_out  out  1  timer output; after reset equals inv
- count_dir  out  1  1 = counting down; reset 0

## Operation
- Limits:
  - lo = force_free ? 0 : count_min
  - hi = force_free ? 8'hFF : count_max
  - All compares are unsigned.
- Tick source, internal (clock_select=0):
  - Prescale counter runs while start=1.
  - It is cleared when start=0 or cnt_init_wr=1.
  - tick fires when the prescale counter equals 2^prescaler−1, then the counter returns to 0.
  - prescaler=0 gives a tick every cycle.
- Tick source, external (clock_select=1):
  - ext_clk_in passes through a 2-flop synchronizer, then an edge detector.
  - Each selected edge gives one tick.
  - The prescaler is bypassed.
  - Ticks are gated by start.
- Count update priority:
  - cnt_init_wr: count←count_init, count_dir←0. No overflow/match pulse. Acts even when start=0.
  - Else tick, up mode: if count ≥ hi then count←lo and overflow=1; else count+1.
  - Else tick, up/down mode, direction up: if count ≥ hi then count_dir←1 and count−1; else count+1.
  - Else tick, up/down mode, direction down: if count ≤ lo then count_dir←0, count+1, overflow=1; else count−1.
  - Else: hold.
- Limits never reached:
  - If count_min > count_max, up mode reloads lo on every tick with overflow each tick.
  - A count above hi wraps on the next tick.
- match_n is 1 for one cycle when a tick makes count equal match_n_value.
- tmr_out = raw ^ inv, where raw is a register:
  - Toggle mode: raw flips on each match_0 event.
  - PWM mode: raw ← (count_next < match_0_value) on every cycle.
  - raw clears when pwm_mode changes.
- start=0: count and count_dir hold, no events, tmr_out holds.

## Timing
- count, overflow, match_0, match_1 are registered together. An event pulse is visible in the same cycle as the new count value.
- Internal clock:
  - First start=1 sampled at edge k gives the first increment at edge k + 2^prescaler − 1.
  - Steady period is 2^prescaler cycles.
- External clock: a selected edge on ext_clk_in updates count 3 edges later.
- Minimum external pulse width is 2 clk periods.
- Load: cnt_init_wr sampled at edge k gives count_init visible after edge k.
- A tick in the same cycle as the load is discarded.
- Reset mid-run: all outputs return to their reset values immediately. The prescale counter and synchronizer clear.

## Configuration
- TIMER_EXT_CLK_EN defined: the external tick path, clock_select and edge_mode are functional.
- Not defined:
  - The synchronizer and edge detector are absent.
  - The tick source is always the prescaler.
  - clock_select, edge_mode and ext_clk_in are ignored; the ports remain.

## Structure
- Shared package timer_pkg holds:
  - WIDTH/PRE_W constants
  - count_mode and output-mode enums
  - reset constants shared with the register file
- Sub-module timer_tick_gen holds the prescale counter, synchronizer, edge detector and tick mux.
- The core holds the count/direction logic, the comparators and tmr_out.

## Test plan
- Sawtooth: prescaler=0, min=0, max=3, start=1 -> count 1,2,3,0,1; overflow high only in the cycle count=0; period 4 cycles.
- Prescale: prescaler=2, force_free=1 -> count increments every 4 cycles; 0xFF→0x00 with overflow.
- Triangle: count_mode=1, min=2, max=5, load 2 -> 3,4,5,4,3,2,3; count_dir=1 from 5→4 through 3→2; overflow only on 2→3.
- Load vs tick: cnt_init_wr with count_init=0x80 in a tick cycle -> count=0x80, no overflow; match_0_value=0x81 -> match_0 on the next tick only.
- PWM: pwm_mode=1, match_0_value=0x40, force_free -> tmr_out high for 64 of 256 ticks; inv=1 gives the complement.
- External (TIMER_EXT_CLK_EN): clock_select=1, edge_mode=1, 5 falling edges -> count=5, each update 3 cycles after its edge; rising edges ignored.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared timer definitions: widths, mode encodings and reset values used by the
// register file and the counting engine.
package timer_pkg;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned PRE_W     = 3;
    // Prescale counter must hold up to 2^(2^PRE_W - 1) - 1.
    localparam int unsigned PRE_CNT_W = (1 << PRE_W) - 1;

    typedef enum logic {
        CntUp     = 1'b0,
        CntUpDown = 1'b1
    } count_mode_e;

    typedef enum logic {
        OutToggle = 1'b0,
        OutPwm    = 1'b1
    } out_mode_e;

    localparam logic [WIDTH-1:0] COUNT_RST      = '0;
    localparam logic             COUNT_DIR_RST  = 1'b0;
    localparam logic             EVENT_RST      = 1'b0;
    localparam logic             RAW_OUT_RST    = 1'b0;
    localparam logic [WIDTH-1:0] COUNT_FREE_MAX = '1;

endpackage

// File: rtl/timer_count_core_if.sv
// Control/status bundle between the timer register file (master) and the
// counting engine (slave).
interface timer_count_core_if;
    import timer_pkg::*;

    logic             start;
    logic             count_mode;
    logic             clock_select;
    logic             edge_mode;
    logic [PRE_W-1:0] prescaler;
    logic             force_free;
    logic [WIDTH-1:0] count_init;
    logic             cnt_init_wr;
    logic [WIDTH-1:0] count_min;
    logic [WIDTH-1:0] count_max;
    logic [WIDTH-1:0] match_0_value;
    logic [WIDTH-1:0] match_1_value;
    logic             pwm_mode;
    logic             inv;
    logic             ext_clk_in;

    logic [WIDTH-1:0] count;
    logic             overflow;
    logic             match_0;
    logic             match_1;
    logic             tmr_out;
    logic             count_dir;

    modport master (
        output start, count_mode, clock_select, edge_mode, prescaler, force_free,
               count_init, cnt_init_wr, count_min, count_max, match_0_value,
               match_1_value, pwm_mode, inv, ext_clk_in,
        input  count, overflow, match_0, match_1, tmr_out, count_dir
    );

    modport slave (
        input  start, count_mode, clock_select, edge_mode, prescaler, force_free,
               count_init, cnt_init_wr, count_min, count_max, match_0_value,
               match_1_value, pwm_mode, inv, ext_clk_in,
        output count, overflow, match_0, match_1, tmr_out, count_dir
    );

endinterface

// File: rtl/timer_tick_gen.sv
// Tick source for the timer: prescale counter, and (with TIMER_EXT_CLK_EN)
// an external-input synchronizer, edge detector and source mux.
module timer_tick_gen
    import timer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             cnt_init_wr_i,
    input  logic [PRE_W-1:0] prescaler_i,
    input  logic             clock_select_i,
    input  logic             edge_mode_i,
    input  logic             ext_clk_in_i,
    output logic             tick_o
);

    logic [PRE_CNT_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [PRE_CNT_W-1:0] pre_mask;
    logic                 int_tick;

    // Terminal value is 2^prescaler - 1.
    assign pre_mask = ~({PRE_CNT_W{1'b1}} << prescaler_i);
    assign int_tick = start_i && (pre_cnt_q == pre_mask);

    // Prescale next state: restart on stop, load or terminal count.
    always_comb begin
        pre_cnt_d = pre_cnt_q + PRE_CNT_W'(1);
        if (!start_i || cnt_init_wr_i || int_tick) begin
            pre_cnt_d = '0;
        end
    end

    // Prescale counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

`ifdef TIMER_EXT_CLK_EN
    // [0],[1] synchronize; [2] holds the previous synchronized level.
    logic [2:0] sync_q;
    logic       ext_edge;

    // External input synchronizer and edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], ext_clk_in_i};
        end
    end

    assign ext_edge = edge_mode_i ? (sync_q[2] & ~sync_q[1]) : (~sync_q[2] & sync_q[1]);
    assign tick_o   = clock_select_i ? (start_i & ext_edge) : int_tick;
`else
    logic unused_ext;
    assign unused_ext = ^{clock_select_i, edge_mode_i, ext_clk_in_i};
    assign tick_o     = int_tick;
`endif

endmodule

// File: rtl/timer_count_core.sv
// Timer counting engine: count/direction update, overflow and match events,
// and the toggle/PWM output. External tick source enabled by TIMER_EXT_CLK_EN.
module timer_count_core
    import timer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    timer_count_core_if.slave  bus
);

    logic             tick;
    logic             evt;
    logic [WIDTH-1:0] lo, hi;
    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             ovf_q, ovf_d;
    logic             m0_q, m0_d;
    logic             m1_q, m1_d;
    logic             raw_q, raw_d;
    logic             pwm_q;

    timer_tick_gen u_tick_gen (
        .clk            (clk),
        .rst            (rst),
        .start_i        (bus.start),
        .cnt_init_wr_i  (bus.cnt_init_wr),
        .prescaler_i    (bus.prescaler),
        .clock_select_i (bus.clock_select),
        .edge_mode_i    (bus.edge_mode),
        .ext_clk_in_i   (bus.ext_clk_in),
        .tick_o         (tick)
    );

    assign lo  = bus.force_free ? '0 : bus.count_min;
    assign hi  = bus.force_free ? COUNT_FREE_MAX : bus.count_max;
    // A load swallows any coincident tick.
    assign evt = tick & ~bus.cnt_init_wr;

    // Count and direction next state with load > tick > hold priority.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        ovf_d   = 1'b0;
        if (bus.cnt_init_wr) begin
            count_d = bus.count_init;
            dir_d   = 1'b0;
        end else if (tick) begin
            if (count_mode_e'(bus.count_mode) == CntUp) begin
                if (count_q >= hi) begin
                    count_d = lo;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else if (!dir_q) begin
                if (count_q >= hi) begin
                    dir_d   = 1'b1;
                    count_d = count_q - WIDTH'(1);
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q <= lo) begin
                    dir_d   = 1'b0;
                    count_d = count_q + WIDTH'(1);
                    ovf_d   = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    assign m0_d = evt && (count_d == bus.match_0_value);
    assign m1_d = evt && (count_d == bus.match_1_value);

    // Raw output next state; a mode change restarts it from 0.
    always_comb begin
        raw_d = raw_q;
        if (bus.pwm_mode != pwm_q) begin
            raw_d = 1'b0;
        end else if (out_mode_e'(bus.pwm_mode) == OutPwm) begin
            if (bus.start) begin
                raw_d = (count_d < bus.match_0_value);
            end
        end else if (m0_d) begin
            raw_d = ~raw_q;
        end
    end

    // Count, events and output state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= COUNT_RST;
            dir_q   <= COUNT_DIR_RST;
            ovf_q   <= EVENT_RST;
            m0_q    <= EVENT_RST;
            m1_q    <= EVENT_RST;
            raw_q   <= RAW_OUT_RST;
            pwm_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            ovf_q   <= ovf_d;
            m0_q    <= m0_d;
            m1_q    <= m1_d;
            raw_q   <= raw_d;
            pwm_q   <= bus.pwm_mode;
        end
    end

    assign bus.count     = count_q;
    assign bus.count_dir = dir_q;
    assign bus.overflow  = ovf_q;
    assign bus.match_0   = m0_q;
    assign bus.match_1   = m1_q;
    assign bus.tmr_out   = raw_q ^ bus.inv;

endmodule

// File: tb/tb_timer_count_core.sv
// Directed bench for timer_count_core.
module tb_timer_count_core;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    int   highs;

    timer_count_core_if bus_if ();

    timer_count_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] saw_cnt [5] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
    logic       saw_ovf [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       saw_m1  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] tri_cnt [7] = '{8'd3, 8'd4, 8'd5, 8'd4, 8'd3, 8'd2, 8'd3};
    logic       tri_dir [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       tri_ovf [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus_if.start         = 1'b0;
        bus_if.count_mode    = 1'b0;
        bus_if.clock_select  = 1'b0;
        bus_if.edge_mode     = 1'b0;
        bus_if.prescaler     = 3'd0;
        bus_if.force_free    = 1'b0;
        bus_if.count_init    = 8'h00;
        bus_if.cnt_init_wr   = 1'b0;
        bus_if.count_min     = 8'h00;
        bus_if.count_max     = 8'h03;
        bus_if.match_0_value = 8'hAA;
        bus_if.match_1_value = 8'h02;
        bus_if.pwm_mode      = 1'b0;
        bus_if.inv           = 1'b0;
        bus_if.ext_clk_in    = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_count", bus_if.count, 8'h00);
        chk("rst_ovf", bus_if.overflow, 1'b0);
        chk("rst_m0", bus_if.match_0, 1'b0);
        chk("rst_m1", bus_if.match_1, 1'b0);
        chk("rst_dir", bus_if.count_dir, 1'b0);
        chk("rst_tmr_out", bus_if.tmr_out, 1'b0);
        bus_if.inv = 1'b1;
        #1;
        chk("rst_tmr_out_inv", bus_if.tmr_out, 1'b1);
        bus_if.inv = 1'b0;
        rst = 1'b0;
        step();
        chk("idle_count", bus_if.count, 8'h00);

        // Sawtooth 0..3, prescaler 0
        bus_if.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("saw_cnt%0d", i), bus_if.count, saw_cnt[i]);
            chk($sformatf("saw_ovf%0d", i), bus_if.overflow, saw_ovf[i]);
            chk($sformatf("saw_m1_%0d", i), bus_if.match_1, saw_m1[i]);
        end
        bus_if.start = 1'b0;
        step();
        chk("stop_hold_count", bus_if.count, 8'h01);
        chk("stop_no_ovf", bus_if.overflow, 1'b0);

        // Prescale /4, free-running FE -> FF -> 00
        bus_if.prescaler   = 3'd2;
        bus_if.force_free  = 1'b1;
        bus_if.count_init  = 8'hFE;
        bus_if.cnt_init_wr = 1'b1;
        step();
        chk("pre_load", bus_if.count, 8'hFE);
        bus_if.cnt_init_wr = 1'b0;
        bus_if.start       = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk($sformatf("pre_cnt%0d", i), bus_if.count,
                (i < 4) ? 8'hFE : ((i < 8) ? 8'hFF : 8'h00));
            chk($sformatf("pre_ovf%0d", i), bus_if.overflow, (i == 8) ? 1'b1 : 1'b0);
        end
        bus_if.start = 1'b0;

        // Triangle between 2 and 5
        bus_if.prescaler   = 3'd0;
        bus_if.count_mode  = 1'b1;
        bus_if.force_free  = 1'b0;
        bus_if.count_min   = 8'h02;
        bus_if.count_max   = 8'h05;
        bus_if.count_init  = 8'h02;
        bus_if.cnt_init_wr = 1'b1;
        step();
        chk("tri_load", bus_if.count, 8'h02);
        chk("tri_load_ovf", bus_if.overflow, 1'b0);
        bus_if.cnt_init_wr = 1'b0;
        bus_if.start       = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("tri_cnt%0d", i), bus_if.count, tri_cnt[i]);
            chk($sformatf("tri_dir%0d", i), bus_if.count_dir, tri_dir[i]);
            chk($sformatf("tri_ovf%0d", i), bus_if.overflow, tri_ovf[i]);
        end
        bus_if.start = 1'b0;
        step();

        // Load in a tick cycle wins; match_0 on the following tick; toggle output
        bus_if.count_mode    = 1'b0;
        bus_if.force_free    = 1'b1;
        bus_if.match_0_value = 8'h81;
        bus_if.count_init    = 8'h80;
        bus_if.cnt_init_wr   = 1'b1;
        bus_if.start         = 1'b1;
        step();
        chk("ld_count", bus_if.count, 8'h80);
        chk("ld_ovf", bus_if.overflow, 1'b0);
        chk("ld_m0", bus_if.match_0, 1'b0);
        bus_if.cnt_init_wr = 1'b0;
        step();
        chk("ld_next_count", bus_if.count, 8'h81);
        chk("ld_next_m0", bus_if.match_0, 1'b1);
        chk("toggle_out", bus_if.tmr_out, 1'b1);
        step();
        chk("ld_after_count", bus_if.count, 8'h82);
        chk("ld_after_m0", bus_if.match_0, 1'b0);
        chk("toggle_hold", bus_if.tmr_out, 1'b1);

        // Inverted limits: every tick reloads min with overflow
        bus_if.force_free = 1'b0;
        bus_if.count_min  = 8'h0A;
        bus_if.count_max  = 8'h05;
        step();
        chk("inv_lim_cnt0", bus_if.count, 8'h0A);
        chk("inv_lim_ovf0", bus_if.overflow, 1'b1);
        step();
        chk("inv_lim_cnt1", bus_if.count, 8'h0A);
        chk("inv_lim_ovf1", bus_if.overflow, 1'b1);
        bus_if.start = 1'b0;
        step();
        chk("inv_lim_stop_ovf", bus_if.overflow, 1'b0);

        // PWM duty 64/256, then inverted
        bus_if.pwm_mode = 1'b1;
        step();
        chk("pwm_switch_clear", bus_if.tmr_out, 1'b0);
        bus_if.match_0_value = 8'h40;
        bus_if.force_free    = 1'b1;
        bus_if.count_init    = 8'h00;
        bus_if.cnt_init_wr   = 1'b1;
        step();
        bus_if.cnt_init_wr = 1'b0;
        bus_if.start       = 1'b1;
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            highs += int'(bus_if.tmr_out);
        end
        chk("pwm_duty", highs, 64);
        bus_if.inv = 1'b1;
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            highs += int'(bus_if.tmr_out);
        end
        chk("pwm_duty_inv", highs, 192);
        chk("pwm_wrap_count", bus_if.count, 8'h00);
        chk("pwm_wrap_ovf", bus_if.overflow, 1'b1);

        // Asynchronous reset mid-run
        step();
        chk("run_count", bus_if.count, 8'h01);
        rst = 1'b1;
        #1;
        chk("async_rst_count", bus_if.count, 8'h00);
        chk("async_rst_tmr_out", bus_if.tmr_out, 1'b1);
        step();
        rst             = 1'b0;
        bus_if.start    = 1'b0;
        bus_if.inv      = 1'b0;
        bus_if.pwm_mode = 1'b0;
        step();

        // External falling-edge source, or clock_select ignored in default build
        bus_if.clock_select = 1'b1;
        bus_if.edge_mode    = 1'b1;
        bus_if.prescaler    = 3'd0;
        bus_if.count_init   = 8'h00;
        bus_if.cnt_init_wr  = 1'b1;
        step();
        bus_if.cnt_init_wr = 1'b0;
        bus_if.start       = 1'b1;
`ifdef TIMER_EXT_CLK_EN
        for (int i = 0; i < 5; i++) begin
            bus_if.ext_clk_in = 1'b1;
            step();
            step();
            step();
            chk($sformatf("ext_rise_ignored%0d", i), bus_if.count, i);
            bus_if.ext_clk_in = 1'b0;
            step();
            step();
            chk($sformatf("ext_not_yet%0d", i), bus_if.count, i);
            step();
            chk($sformatf("ext_fall%0d", i), bus_if.count, i + 1);
        end
        chk("ext_total", bus_if.count, 8'h05);
`else
        step();
        step();
        step();
        chk("clksel_ignored", bus_if.count, 8'h03);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
